// File: rtl/tdc_pkg.sv
// tdc_pkg: shared widths, packet constants, FSM state type and packet byte selector
package tdc_pkg;
    localparam int MEAS_W  = 40;
    localparam int SEQ_W   = 8;
    localparam int PKT_LEN = 8;
    localparam int ENTRY_W = MEAS_W + SEQ_W;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    // Byte idx of a packet built from a stored {seq, meas} entry; byte 7 is the XOR of bytes 1..6
    function automatic logic [7:0] pkt_byte(input logic [ENTRY_W-1:0] p, input logic [2:0] idx,
                                            input logic [7:0] sync);
        logic [7:0]         chk;
        logic [5:0]         amt;
        logic [ENTRY_W-1:0] sh;
        chk = p[47:40] ^ p[39:32] ^ p[31:24] ^ p[23:16] ^ p[15:8] ^ p[7:0];
        amt = {3'd6 - idx, 3'b000};
        sh  = p >> amt;
        return (idx == 3'd0) ? sync : (idx == 3'd7) ? chk : sh[7:0];
    endfunction
endpackage

// File: rtl/tdc_sync_fifo.sv
// tdc_sync_fifo: single-clock FIFO; a pop on a full FIFO lets a same-cycle push through
module tdc_sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp, r_rp;
    logic [AW:0]      r_level;
    logic             w_push, w_pop;

    assign o_full  = r_level == (AW+1)'(DEPTH);
    assign o_empty = r_level == '0;
    assign o_level = r_level;
    assign o_dout  = r_mem[r_rp];
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wp] <= i_din;
    end
endmodule

// File: rtl/tdc_result_packetizer.sv
// tdc_result_packetizer: buffers sequence-tagged TDC measurements and streams them
// out as 8-byte checksummed packets on a valid/ready byte interface
module tdc_result_packetizer
    import tdc_pkg::*;
#(
    parameter int         DEPTH     = 4,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [MEAS_W-1:0]        i_meas_in,
    input  logic                     i_meas_valid,
    output logic [7:0]               o_tx_data,
    output logic                     o_tx_valid,
    input  logic                     i_tx_ready,
    input  logic                     i_clr_overflow,
    output logic                     o_overflow,
    output logic [7:0]               o_drop_count,
    output logic [$clog2(DEPTH):0]   o_fifo_level,
    output logic                     o_busy
);
    state_t             r_state, w_next;
    logic [SEQ_W-1:0]   r_seq;
    logic [ENTRY_W-1:0] r_pkt, w_head;
    logic [2:0]         r_idx;
    logic [7:0]         r_tx_data, r_drop;
    logic               r_tx_valid, r_overflow;
    logic               w_full, w_empty, w_pop, w_hs, w_last, w_drop;

    tdc_sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_meas_valid),
        .i_din   ({r_seq, i_meas_in}),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_fifo_level)
    );

    assign w_pop  = (r_state == ST_IDLE) & ~w_empty;
    assign w_hs   = r_tx_valid & i_tx_ready;
    assign w_last = r_idx == 3'(PKT_LEN - 1);
    assign w_drop = i_meas_valid & w_full & ~w_pop;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == ST_IDLE) w_next = w_empty ? ST_IDLE : ST_SEND;
        else                    w_next = (w_hs && w_last) ? ST_IDLE : ST_SEND;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_seq      <= '0;
            r_pkt      <= '0;
            r_idx      <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_overflow <= 1'b0;
            r_drop     <= '0;
        end else begin
            if (i_meas_valid) r_seq <= r_seq + 1'b1;
            // A drop outranks a coincident clear so no loss goes unreported
            r_overflow <= w_drop | (r_overflow & ~i_clr_overflow);
            r_drop     <= w_drop ? (i_clr_overflow ? 8'd1 : (r_drop == 8'hFF ? r_drop : r_drop + 8'd1))
                                 : (i_clr_overflow ? 8'd0 : r_drop);
            if (w_pop) begin
                r_pkt      <= w_head;
                r_idx      <= '0;
                r_tx_data  <= SYNC_BYTE;
                r_tx_valid <= 1'b1;
            end else if (r_state == ST_SEND && w_hs) begin
                if (w_last) begin
                    r_tx_valid <= 1'b0;
                end else begin
                    r_idx     <= r_idx + 3'd1;
                    r_tx_data <= pkt_byte(r_pkt, r_idx + 3'd1, SYNC_BYTE);
                end
            end
        end
    end

    assign o_tx_data    = r_tx_data;
    assign o_tx_valid   = r_tx_valid;
    assign o_overflow   = r_overflow;
    assign o_drop_count = r_drop;
    assign o_busy       = r_state == ST_SEND;
endmodule

// File: tb/tb_tdc_result_packetizer.sv
// tb_tdc_result_packetizer: directed stimulus with a byte scoreboard checked by a
// decoupled stream monitor
module tb_tdc_result_packetizer;
    logic        clk, rst_n, meas_valid, tx_ready, clr_overflow;
    logic [39:0] meas_in;
    logic [7:0]  tx_data, drop_count;
    logic        tx_valid, overflow, busy;
    logic [2:0]  fifo_level;

    logic [7:0]  exp_q[$];
    int          n_checks, n_err;
    logic        prev_stall;
    logic [7:0]  prev_data;

    localparam logic [39:0] BASE = 40'h11_2233_4400;
    localparam logic [15:0] PAT  = 16'b1011_0010_0110_1001;

    tdc_result_packetizer #(.DEPTH(4), .SYNC_BYTE(8'hA5)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_meas_in      (meas_in),
        .i_meas_valid   (meas_valid),
        .o_tx_data      (tx_data),
        .o_tx_valid     (tx_valid),
        .i_tx_ready     (tx_ready),
        .i_clr_overflow (clr_overflow),
        .o_overflow     (overflow),
        .o_drop_count   (drop_count),
        .o_fifo_level   (fifo_level),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pkt(input logic [7:0] seq, input logic [39:0] m, input logic [7:0] chk);
        exp_q.push_back(8'hA5);
        exp_q.push_back(seq);
        for (int b = 4; b >= 0; b--) exp_q.push_back(m[8*b +: 8]);
        exp_q.push_back(chk);
    endtask

    task automatic pulse(input logic [39:0] m);
        meas_in    = m;
        meas_valid = 1'b1;
        tick();
        meas_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        meas_valid   = 1'b0;
        clr_overflow = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drain(input int budget, input bit use_pat);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < budget) begin
            if (use_pat) tx_ready = PAT[k % 16];
            tick();
            k++;
        end
        tx_ready = 1'b1;
        if (k >= budget) begin
            n_checks++;
            n_err++;
            $display("FAIL drain_timeout: %0d bytes still expected", exp_q.size());
        end
    endtask

    // Stream monitor: compares each accepted byte and checks stall stability
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) check("stall_hold", {tx_valid, tx_data}, {1'b1, prev_data});
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL byte_extra: got %0h expected none", tx_data);
                end else begin
                    check("byte", tx_data, exp_q.pop_front());
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        int hi;
        n_checks     = 0;
        n_err        = 0;
        prev_stall   = 1'b0;
        prev_data    = '0;
        meas_in      = '0;
        tx_ready     = 1'b0;
        rst_n        = 1'b0;
        meas_valid   = 1'b0;
        clr_overflow = 1'b0;
        tick();
        tick();
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop", drop_count, 0);
        check("rst_level", fifo_level, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        // T1: single packet, latency and length; checksum 00^12^34^56^78^00 = 08
        tx_ready = 1'b1;
        expect_pkt(8'h00, 40'h00_1234_5678, 8'h08);
        pulse(40'h00_1234_5678);
        check("t1_valid_e0", tx_valid, 0);
        check("t1_level_e0", fifo_level, 1);
        tick();
        check("t1_valid_e1", tx_valid, 1);
        check("t1_sync_e1", tx_data, 8'hA5);
        check("t1_busy_e1", busy, 1);
        check("t1_level_e1", fifo_level, 0);
        hi = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            hi += int'(tx_valid);
        end
        check("t1_valid_cycles", hi, 8);

        // T2: ready pattern with stalls; checksum 01^AB^CD^EF^01^23 = AA
        tx_ready = 1'b0;
        expect_pkt(8'h01, 40'hAB_CDEF_0123, 8'hAA);
        pulse(40'hAB_CDEF_0123);
        drain(200, 1'b1);

        // T3: overflow with ready low; low byte == seq makes every checksum 44
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) expect_pkt(8'(i), BASE + 40'(i), 8'h44);
        for (int i = 0; i < 7; i++) pulse(BASE + 40'(i));
        check("t3_level", fifo_level, 4);
        check("t3_drop", drop_count, 2);
        check("t3_overflow", overflow, 1);
        check("t3_stalled_sync", {busy, tx_valid, tx_data}, {2'b11, 8'hA5});
        tx_ready = 1'b1;
        drain(100, 1'b0);
        expect_pkt(8'h07, BASE + 40'd7, 8'h44);
        pulse(BASE + 40'd7);
        drain(30, 1'b0);

        // T4: push on the same cycle as an IDLE pop of a full FIFO
        tx_ready = 1'b0;
        for (int i = 8; i < 13; i++) expect_pkt(8'(i), BASE + 40'(i), 8'h44);
        for (int i = 8; i < 13; i++) pulse(BASE + 40'(i));
        check("t4_full_level", fifo_level, 4);
        tx_ready = 1'b1;
        hi = 0;
        while (busy && hi < 20) begin
            tick();
            hi++;
        end
        check("t4_idle_reached", busy, 0);
        check("t4_level_at_idle", fifo_level, 4);
        expect_pkt(8'h0D, BASE + 40'h0D, 8'h44);
        pulse(BASE + 40'h0D);
        check("t4_level_after", fifo_level, 4);
        check("t4_drop_same", drop_count, 2);
        check("t4_busy", busy, 1);
        drain(200, 1'b0);

        // T5: 262 pulses with ready low: 5 accepted, 257 dropped -> saturation and seq wrap
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) expect_pkt(8'(i), BASE + 40'(i), 8'h44);
        meas_valid = 1'b1;
        for (int i = 0; i < 262; i++) begin
            meas_in = BASE + 40'(i);
            tick();
            if (i == 258) check("t5_drop_fe", drop_count, 8'hFE);
            if (i == 259) check("t5_drop_ff", drop_count, 8'hFF);
        end
        meas_valid = 1'b0;
        check("t5_drop_sat", drop_count, 8'hFF);
        check("t5_overflow", overflow, 1);
        check("t5_level", fifo_level, 4);
        meas_valid   = 1'b1;
        clr_overflow = 1'b1;
        tick();
        meas_valid = 1'b0;
        check("t5_clr_drop_wins_ovf", overflow, 1);
        check("t5_clr_drop_wins_cnt", drop_count, 1);
        tick();
        clr_overflow = 1'b0;
        check("t5_clr_ovf", overflow, 0);
        check("t5_clr_cnt", drop_count, 0);
        tx_ready = 1'b1;
        drain(100, 1'b0);
        expect_pkt(8'h07, BASE + 40'd7, 8'h44);
        pulse(BASE + 40'd7);
        drain(30, 1'b0);

        // T6: reset while byte 4 (meas[23:16]) is presented
        do_reset();
        tx_ready = 1'b1;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        pulse(BASE);
        for (int i = 0; i < 5; i++) tick();
        check("t6_byte4", {tx_valid, tx_data}, {1'b1, 8'h33});
        rst_n = 1'b0;
        tick();
        check("t6_rst_valid", tx_valid, 0);
        check("t6_rst_level", fifo_level, 0);
        check("t6_rst_busy", busy, 0);
        rst_n = 1'b1;
        expect_pkt(8'h00, BASE, 8'h44);
        pulse(BASE);
        drain(30, 1'b0);
        tick();
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
